lotr_input_conditioner: RTL



---
 rtl/lotr_input_conditioner_pkg.sv | 15 +
 rtl/lotr_input_conditioner_if.sv | 25 ++
 rtl/lotr_input_conditioner_debounce.sv | 50 +++++
 rtl/lotr_input_conditioner.sv | 123 ++++++++++++
 4 files changed

// File: rtl/lotr_input_conditioner_pkg.sv
// Shared sizes and event-vector layout for the lotr board input conditioner.
package lotr_io_pkg;

   localparam int NUM_BTN       = 2;
   localparam int NUM_SW        = 10;
   localparam int NUM_EV        = NUM_BTN + NUM_SW;
   localparam int DB_CYCLES_DEF = 50000;   // 10 ms at 5 MHz

   typedef logic [NUM_EV-1:0] t_ev_vec;

   // Event vector is {Sw, Btn}: buttons occupy the low bits.
   localparam int EV_BTN0 = 0;
   localparam int EV_SW0  = NUM_BTN;

endpackage

// File: rtl/lotr_input_conditioner_if.sv
// Pin-side and core-side signals of the input conditioner.
// slave = the conditioner itself, master = whoever drives pins and EvClr.
interface lotr_input_conditioner_if;

   logic [lotr_io_pkg::NUM_BTN-1:0] Button;
   logic [lotr_io_pkg::NUM_SW-1:0]  Switch;
   logic [lotr_io_pkg::NUM_BTN-1:0] BtnLevel;
   logic [lotr_io_pkg::NUM_BTN-1:0] BtnPulse;
   logic [lotr_io_pkg::NUM_SW-1:0]  SwLevel;
   logic [lotr_io_pkg::NUM_SW-1:0]  SwChgPulse;
   lotr_io_pkg::t_ev_vec            EvSticky;
   lotr_io_pkg::t_ev_vec            EvClr;
   logic                            InitDone;

   modport master (
      output Button, Switch, EvClr,
      input  BtnLevel, BtnPulse, SwLevel, SwChgPulse, EvSticky, InitDone
   );

   modport slave (
      input  Button, Switch, EvClr,
      output BtnLevel, BtnPulse, SwLevel, SwChgPulse, EvSticky, InitDone
   );

endinterface

// File: rtl/lotr_input_conditioner_debounce.sv
// One-bit conditioner: 2-FF synchronizer, stability counter, accepted level
// and a registered change pulse aligned with the level update.
// The pin polarity is untouched here; RST_LVL is the idle pin level.
module lotr_debounce #(
   parameter int   DB_CYCLES = 50000,
   parameter logic RST_LVL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   input  logic en,      // change pulses suppressed while low
   output logic level,
   output logic chg
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;
   logic          accept;

   // New level taken only after sync has differed for a full window.
   assign accept = (sync2 != level) && (cnt == CW'(DB_CYCLES - 1));

   // Two-stage synchronizer, idle at the pin's rest level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RST_LVL;
         sync2 <= RST_LVL;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // Stability counter, accepted level and change pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= RST_LVL;
         chg   <= 1'b0;
      end else begin
         chg <= en & accept;
         if (sync2 == level || accept) cnt <= '0;
         else                          cnt <= cnt + 1'b1;
         if (accept) level <= sync2;
      end
   end

endmodule

// File: rtl/lotr_input_conditioner.sv
// Board input conditioner for lotr: debounces buttons (active-low pins) and
// slide switches, generates press/change pulses, a power-up settle flag and a
// sticky event register cleared by the core.
// Optional build macro BTN_REPEAT_EN adds button auto-repeat while held.
module lotr_input_conditioner
   import lotr_io_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef BTN_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 2500000,
   parameter int REPEAT_PERIOD = 500000
`endif
) (
   input  logic                   QClk,
   input  logic                   RstQnnnL,
   lotr_input_conditioner_if.slave io
);

   localparam int IW = $clog2(DB_CYCLES + 2);

   logic [IW-1:0]      init_cnt;
   logic               init_done;
   logic [NUM_BTN-1:0] btn_pin_lvl, btn_lvl, btn_chg, btn_rep, btn_pulse;
   logic [NUM_SW-1:0]  sw_lvl, sw_chg;
   t_ev_vec            ev_set, ev_q;

   // Settle flag: first full debounce window after reset, then sticks.
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else if (!init_done) begin
         if (init_cnt == IW'(DB_CYCLES + 1)) init_done <= 1'b1;
         else                                init_cnt  <= init_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      lotr_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LVL(1'b1)) u_db (
         .clk   (QClk),
         .rst_n (RstQnnnL),
         .pin   (io.Button[i]),
         .en    (init_done),
         .level (btn_pin_lvl[i]),
         .chg   (btn_chg[i])
      );
   end

   for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
      lotr_debounce #(.DB_CYCLES(DB_CYCLES), .RST_LVL(1'b0)) u_db (
         .clk   (QClk),
         .rst_n (RstQnnnL),
         .pin   (io.Switch[j]),
         .en    (init_done),
         .level (sw_lvl[j]),
         .chg   (sw_chg[j])
      );
   end

   // Pins are active-low; a change that leaves the button pressed is a press.
   // A repeat registered on the release cycle is masked by the falling level.
   assign btn_lvl   = ~btn_pin_lvl;
   assign btn_pulse = (btn_chg | btn_rep) & btn_lvl;

`ifdef BTN_REPEAT_EN
   localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(HMAX + 1);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_rep
      logic [HW-1:0] hold_cnt;
      logic          in_period;
      logic          rep;

      // Hold timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
      always_ff @(posedge QClk or negedge RstQnnnL) begin
         if (!RstQnnnL) begin
            hold_cnt  <= '0;
            in_period <= 1'b0;
            rep       <= 1'b0;
         end else begin
            rep <= 1'b0;
            if (!btn_lvl[i]) begin
               hold_cnt  <= '0;
               in_period <= 1'b0;
            end else if ((!in_period && hold_cnt == HW'(REPEAT_DELAY - 1)) ||
                         ( in_period && hold_cnt == HW'(REPEAT_PERIOD - 1))) begin
               rep       <= init_done;
               hold_cnt  <= '0;
               in_period <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end

      assign btn_rep[i] = rep;
   end
`else
   assign btn_rep = '0;
`endif

   // Event set vector in {Sw, Btn} layout.
   always_comb begin
      ev_set                      = '0;
      ev_set[EV_BTN0 +: NUM_BTN]  = btn_pulse;
      ev_set[EV_SW0  +: NUM_SW]   = sw_chg;
   end

   // Sticky events: clear mask applied first so a same-cycle set wins.
   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) ev_q <= '0;
      else           ev_q <= (ev_q & ~io.EvClr) | ev_set;
   end

   assign io.BtnLevel   = btn_lvl;
   assign io.BtnPulse   = btn_pulse;
   assign io.SwLevel    = sw_lvl;
   assign io.SwChgPulse = sw_chg;
   assign io.EvSticky   = ev_q;
   assign io.InitDone   = init_done;

endmodule
